pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Power-up/lock sequencer for one alta_pllx instance. Runs on the PLL reference clock.
//  Drives pllen, resetn and clkout0en, and qualifies the PLL lock indication.
//  Gates the PLL output until lock has been stable, retries on lock timeout and
//  re-sequences on lock loss. Logic on the PLL output clock uses 'ready' as a release
//  condition.
// PARAMETERS
//  CNT_W          16    width of the shared wait counter; every cycle parameter < 2**CNT_W
//  RESET_CYCLES   16    cycles pll_resetn is held low in RESET (>=1)
//  LOCK_TIMEOUT   4096  max cycles in WAIT_LOCK before a timeout (>=1)
//  SETTLE_CYCLES  256   consecutive synced-lock cycles required before output enable (>=1)
//  MAX_RETRIES    3     timeouts tolerated before FAULT (0 = first timeout faults)
// PORTS
//  clk            in   1  PLL reference clock; all logic posedge clk
//  resetn         in   1  synchronous, active-low reset
//  enable         in   1  level; 1 = run the PLL, 0 = shut down
//  restart        in   1  one-cycle pulse; forces a full re-sequence
//  pll_locked     in   1  PLL lock flag, asynchronous; 2-flop synchronised internally
//  pll_en         out  1  to alta_pllx.pllen
//  pll_resetn     out  1  to alta_pllx.resetn
//  pll_clkout_en  out  1  to alta_pllx.clkout0en
//  ready          out  1  PLL output valid and enabled
//  fault          out  1  retries exhausted; sticky until restart, enable=0 or resetn
//  state          out  3  current state encoding (debug)
//  fault_cnt      out  8  saturating lock-loss+timeout count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=OFF, pll_en=0, pll_resetn=0, pll_clkout_en=0, ready=0, fault=0,
//   fault_cnt=0, retry count=0, wait counter=0, sync flops=0.
//  All outputs are registered and decoded from the state register.
//  lock_s = pll_locked after 2 flops (2-cycle latency).
//  States, encoding and outputs (pll_en/pll_resetn/pll_clkout_en/ready):
//   OFF=0 (0/0/0/0): enable=1 -> RESET, counter=0.
//   RESET=1 (1/0/0/0): counter counts to RESET_CYCLES-1 -> WAIT_LOCK, counter=0.
//   WAIT_LOCK=2 (1/1/0/0): lock_s=1 -> SETTLE, counter=0.
//    Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> timeout:
//    if retries<MAX_RETRIES, retries+1 -> RESET; else -> FAULT.
//   SETTLE=3 (1/1/0/0): lock_s=0 -> counter=0 and stay in SETTLE (glitch filter).
//    SETTLE_CYCLES consecutive lock_s=1 -> RUN, and retries clear to 0.
//   RUN=4 (1/1/1/1): lock_s=0 -> RESET with ready deasserted the same edge.
//    This lock loss does not consume a retry.
//   FAULT=5 (0/0/0/0, fault=1): held until restart or enable=0.
//  Priority, highest first:
//   1. resetn=0
//   2. enable=0 -> OFF from any state, next edge
//   3. restart=1 -> RESET, counter=0, retries=0, fault=0; ignored in OFF
//   4. normal transitions
//  Timing: OFF->RUN with lock already stable =
//   1 + RESET_CYCLES + 2 (sync) + SETTLE_CYCLES cycles from enable rising.
//  Wait counter never wraps: it is compared against the limit and cleared on every
//   state entry.
//  Unused encodings 6,7 -> OFF on the next edge.
//  ready never asserts without pll_clkout_en; both deassert together.
// CONFIGURATION
//  PLL_SEQ_FAULT_CNT_EN defined:
//   fault_cnt increments by 1 on every timeout and every RUN lock loss.
//   Saturates at 255; cleared only by resetn.
//  Not defined: fault_cnt is tied to 8'd0 and no counter logic is built.
//  State machine behaviour is identical in both cases.
// TESTING (RESET_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, MAX_RETRIES=2)
//  T1 lock held 1 from t0, enable rises at cycle 0:
//   -> ready=1 at cycle 15 (1+4+2+8); pll_resetn rises at cycle 5.
//  T2 lock never asserts:
//   -> 3 WAIT_LOCK windows of 32 cycles, each preceded by a 4-cycle RESET.
//   -> fault=1 and pll_en=0 after the 3rd timeout.
//   -> fault_cnt=3 with the macro defined, 0 without.
//  T3 lock 1-cycle low glitch at SETTLE count 6:
//   -> SETTLE restarts; ready is 8 full lock cycles later; no RESET entered.
//  T4 in RUN, drop lock:
//   -> ready/pll_clkout_en fall 3 cycles after pll_locked falls (2 sync + 1).
//   -> state=RESET; re-lock returns to RUN.
//  T5 restart pulse in FAULT:
//   -> RESET next edge, fault=0, retries=0.
//  T5 restart and enable=0 on the same cycle:
//   -> OFF wins.
//  T6 resetn low for 1 cycle while in RUN:
//   -> all outputs at reset values on that edge.
//  T6 unused state encodings:
//   -> force state=6 -> OFF next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Power-up/lock sequencer for one alta_pllx, clocked by the PLL reference clock.
// Define PLL_SEQ_FAULT_CNT_EN to build the saturating timeout/lock-loss counter.
module pll_lock_sequencer #(
  parameter int CNT_W         = 16,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_en,
  output logic       pll_resetn,
  output logic       pll_clkout_en,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] fault_cnt
);

  localparam int RET_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // Kept as a plain vector so the unused encodings 6/7 are representable and recoverable.
  logic [2:0]       state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [RET_W-1:0] retry_reg, retry_next;
  logic [1:0]       sync_reg;
  logic             lock_s;
  logic             timeout_ev, loss_ev;
  logic             pll_en_next, pll_resetn_next, run_next, fault_next;

  assign lock_s = sync_reg[1];
  assign state  = state_reg;

  always_comb begin
    state_next = state_t'(state_reg);
    cnt_next   = cnt_reg;
    retry_next = retry_reg;
    timeout_ev = 1'b0;
    loss_ev    = 1'b0;
    if (!enable) begin
      state_next = ST_OFF;
      cnt_next   = '0;
      retry_next = '0;
    end else if (restart && (state_reg != ST_OFF)) begin
      state_next = ST_RESET;
      cnt_next   = '0;
      retry_next = '0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          state_next = ST_RESET;
          cnt_next   = '0;
        end
        ST_RESET: begin
          if (cnt_reg == RESET_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_next = ST_SETTLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            timeout_ev = 1'b1;
            cnt_next   = '0;
            if (retry_reg < RET_MAX) begin
              retry_next = retry_reg + RET_W'(1);
              state_next = ST_RESET;
            end else begin
              state_next = ST_FAULT;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          // Any dropout restarts the stability window rather than re-resetting the PLL.
          if (!lock_s) begin
            cnt_next = '0;
          end else if (cnt_reg == SETTLE_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            retry_next = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            loss_ev    = 1'b1;
            state_next = ST_RESET;
            cnt_next   = '0;
          end
        end
        ST_FAULT: begin
          state_next = ST_FAULT;
        end
        default: begin
          state_next = ST_OFF;
          cnt_next   = '0;
          retry_next = '0;
        end
      endcase
    end
  end

  assign pll_en_next     = (state_next == ST_RESET) || (state_next == ST_WAIT_LOCK) ||
                           (state_next == ST_SETTLE) || (state_next == ST_RUN);
  assign pll_resetn_next = (state_next == ST_WAIT_LOCK) || (state_next == ST_SETTLE) ||
                           (state_next == ST_RUN);
  assign run_next        = (state_next == ST_RUN);
  assign fault_next      = (state_next == ST_FAULT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= ST_OFF;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      sync_reg      <= '0;
      pll_en        <= 1'b0;
      pll_resetn    <= 1'b0;
      pll_clkout_en <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      pll_en        <= pll_en_next;
      pll_resetn    <= pll_resetn_next;
      pll_clkout_en <= run_next;
      ready         <= run_next;
      fault         <= fault_next;
      // Lock is meaningless while the PLL is held in reset, so stale lock never leaks through.
      if (pll_resetn_next) begin
        sync_reg <= {sync_reg[0], pll_locked};
      end else begin
        sync_reg <= '0;
      end
    end
  end

`ifdef PLL_SEQ_FAULT_CNT_EN
  logic [7:0] fault_cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fault_cnt_reg <= 8'd0;
    end else if ((timeout_ev || loss_ev) && (fault_cnt_reg != 8'hFF)) begin
      fault_cnt_reg <= fault_cnt_reg + 8'd1;
    end
  end

  assign fault_cnt = fault_cnt_reg;
`else
  logic unused_events;
  assign unused_events = timeout_ev | loss_ev;
  assign fault_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: vector table plus hand sequences for glitch and
// illegal-state recovery. Honours PLL_SEQ_FAULT_CNT_EN for fault_cnt expectations.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       resetn, enable, restart, pll_locked;
  logic       pll_en, pll_resetn, pll_clkout_en, ready, fault;
  logic [2:0] state;
  logic [7:0] fault_cnt;

  int tests = 0;
  int fails = 0;

`ifdef PLL_SEQ_FAULT_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .CNT_W(16), .RESET_CYCLES(4), .LOCK_TIMEOUT(32), .SETTLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .restart(restart), .pll_locked(pll_locked),
    .pll_en(pll_en), .pll_resetn(pll_resetn), .pll_clkout_en(pll_clkout_en), .ready(ready),
    .fault(fault), .state(state), .fault_cnt(fault_cnt)
  );

  typedef struct {
    int         cyc;
    logic       rstn, en, rs, lk;
    logic [2:0] st;
    logic [7:0] fc;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  logic [15:0] got, exp;
  bit          bad;

  // Expected {pll_en, pll_resetn, pll_clkout_en, ready, fault} for each state.
  function automatic logic [4:0] exp_outs(input logic [2:0] st);
    case (st)
      3'd1:    return 5'b10000;
      3'd2:    return 5'b11000;
      3'd3:    return 5'b11000;
      3'd4:    return 5'b11110;
      3'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic add(input int cyc, input logic rstn, en, rs, lk,
                     input logic [2:0] st, input logic [7:0] fc);
    vec_t r;
    r.cyc = cyc; r.rstn = rstn; r.en = en; r.rs = rs; r.lk = lk; r.st = st; r.fc = fc;
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, e);
    end else begin
      $display("ok   %s = %0h", nm, g);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; restart = 1'b0; pll_locked = 1'b0;

    //   cyc rstn en rs lk  st  fc
    add(2,  0, 0, 0, 0, 0, 0);   // reset
    add(1,  1, 1, 0, 1, 1, 0);   // T1: enable -> RESET
    add(3,  1, 1, 0, 1, 1, 0);
    add(1,  1, 1, 0, 1, 2, 0);   // pll_resetn rises at cycle 5
    add(1,  1, 1, 0, 1, 2, 0);   // sync latency
    add(1,  1, 1, 0, 1, 3, 0);
    add(7,  1, 1, 0, 1, 3, 0);   // cycle 14: still settling
    add(1,  1, 1, 0, 1, 4, 0);   // cycle 15: ready
    add(1,  1, 1, 0, 0, 4, 0);   // T4: lock drops
    add(1,  1, 1, 0, 0, 4, 0);
    add(1,  1, 1, 0, 0, 1, 1);   // 3 cycles later -> RESET
    add(3,  1, 1, 0, 1, 1, 1);
    add(1,  1, 1, 0, 1, 2, 1);
    add(2,  1, 1, 0, 1, 3, 1);
    add(7,  1, 1, 0, 1, 3, 1);
    add(1,  1, 1, 0, 1, 4, 1);   // re-locked
    add(1,  0, 1, 0, 1, 0, 0);   // T6: resetn pulse in RUN
    add(1,  1, 1, 0, 0, 1, 0);   // T2: lock never comes
    add(4,  1, 1, 0, 0, 2, 0);
    add(31, 1, 1, 0, 0, 2, 0);
    add(1,  1, 1, 0, 0, 1, 1);   // timeout 1
    add(4,  1, 1, 0, 0, 2, 1);
    add(32, 1, 1, 0, 0, 1, 2);   // timeout 2
    add(4,  1, 1, 0, 0, 2, 2);
    add(31, 1, 1, 0, 0, 2, 2);
    add(1,  1, 1, 0, 0, 5, 3);   // timeout 3 -> FAULT
    add(5,  1, 1, 0, 0, 5, 3);   // sticky
    add(1,  1, 1, 1, 0, 1, 3);   // T5: restart in FAULT
    add(4,  1, 1, 0, 0, 2, 3);
    add(32, 1, 1, 0, 0, 1, 4);   // retries were cleared: retry, not FAULT
    add(1,  1, 0, 1, 0, 0, 4);   // restart + enable=0: OFF wins
    add(3,  1, 0, 0, 0, 0, 4);
    add(1,  1, 0, 1, 0, 0, 4);   // restart ignored in OFF
    add(1,  1, 1, 0, 1, 1, 4);
    add(4,  1, 1, 0, 1, 2, 4);
    add(2,  1, 1, 0, 1, 3, 4);
    add(8,  1, 1, 0, 1, 4, 4);

    foreach (vecs[i]) begin
      v = vecs[i];
      resetn = v.rstn; enable = v.en; restart = v.rs; pll_locked = v.lk;
      tick(v.cyc);
      got = {state, pll_en, pll_resetn, pll_clkout_en, ready, fault, fault_cnt};
      exp = {v.st, exp_outs(v.st), (FC_EN ? v.fc : 8'd0)};
      chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
    end
    restart = 1'b0;

    // T3: one-cycle lock dropout at settle count 6 restarts the window, no RESET.
    enable = 1'b0; tick(1);
    chk("t3_off", 32'(state), 32'd0);
    enable = 1'b1; pll_locked = 1'b1; tick(1);
    chk("t3_reset", 32'(state), 32'd1);
    tick(10);
    chk("t3_settle", 32'(state), 32'd3);
    pll_locked = 1'b0; tick(1);
    pll_locked = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      if (state != 3'd3) bad = 1'b1;
    end
    chk("t3_stays_settle", 32'(bad), 32'd0);
    chk("t3_not_ready_yet", 32'({ready, pll_clkout_en}), 32'd0);
    tick(1);
    chk("t3_ready", 32'({state, ready, pll_clkout_en}), 32'({3'd4, 2'b11}));

    // Illegal encoding recovers to OFF on the next edge.
    force dut.state_reg = 3'd6;
    #1;
    release dut.state_reg;
    chk("t6_forced", 32'(state), 32'd6);
    tick(1);
    chk("t6_recover", 32'({state, pll_en, pll_resetn, ready}), 32'({3'd0, 3'b000}));
    tick(1);
    chk("t6_rearm", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
